// File: rtl/motor_pwm_driver_if.sv
// Motor PIO command word in, H-bridge leg drives and status out.
// Latency: none; plain wires.
// Backpressure: none; the command is level-sampled by the driver.
interface motor_pwm_driver_if;
  logic [13:0] motor_cmd;
  logic        pwm_a;
  logic        pwm_b;
  logic        at_target;
  logic [1:0]  state_o;

  modport master (
    output motor_cmd,
    input  pwm_a,
    input  pwm_b,
    input  at_target,
    input  state_o
  );

  modport slave (
    input  motor_cmd,
    output pwm_a,
    output pwm_b,
    output at_target,
    output state_o
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: ramped duty, direction control, all-off dead periods on reversal/stop.
// Latency: command acts at the next PWM period end; legs are registered one clk after the compare.
// Backpressure: none; the command is sampled once per PWM period and may change freely otherwise.
module motor_pwm_driver #(
  parameter int unsigned PRESCALE     = 12,
  parameter int unsigned RAMP_STEP    = 16,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  motor_pwm_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam logic [7:0]  PRESC_MAX = 8'(PRESCALE - 1);
  localparam logic [12:0] STEP13    = 13'(RAMP_STEP);
  localparam logic [3:0]  DEAD_LD   = 4'(DEAD_PERIODS);

  logic [7:0]  presc_q;
  logic [11:0] cnt_q;
  logic        tick;
  logic        period_end;

  state_e      state_q, state_d;
  logic [11:0] duty_q, duty_d;
  logic        dir_q, dir_d;
  logic [3:0]  dead_q, dead_d;

  logic        samp_en_q;
  logic [11:0] samp_tgt_q;

  logic        pwm_a_q, pwm_b_q;

  logic        cmd_en;
  logic        cmd_dir;
  logic [11:0] cmd_tgt;
  logic        keep_run;

  logic [11:0] ramp_tgt;
  logic [12:0] up_sum;
  logic [12:0] dn_diff;
  logic [11:0] ramp_res;
  logic        active;

  assign cmd_en  = bus.motor_cmd[13];
  assign cmd_dir = bus.motor_cmd[12];
  assign cmd_tgt = bus.motor_cmd[11:0];

  // Same direction and enabled: keep driving toward the commanded target; otherwise wind down.
  assign keep_run = cmd_en && (cmd_dir == dir_q);

  assign tick       = (presc_q == PRESC_MAX);
  assign period_end = tick && (cnt_q == 12'hFFF);

  // Prescaler: one tick every PRESCALE clocks, first tick PRESCALE clocks after reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q <= 8'd0;
    end else if (tick) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_q + 8'd1;
    end
  end

  // PWM counter: free-running 12-bit, wraps 4095 -> 0 naturally.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q <= 12'd0;
    end else if (tick) begin
      cnt_q <= cnt_q + 12'd1;
    end
  end

  // Hold the command seen at the last period end; only used for the at_target status.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      samp_en_q  <= 1'b0;
      samp_tgt_q <= 12'd0;
    end else if (period_end) begin
      samp_en_q  <= cmd_en;
      samp_tgt_q <= cmd_tgt;
    end
  end

  // Saturating 13-bit ramp one step toward ramp_tgt; bit 12 of dn_diff flags duty < step.
  always_comb begin
    ramp_tgt = keep_run ? cmd_tgt : 12'd0;
    up_sum   = {1'b0, duty_q} + STEP13;
    dn_diff  = {1'b0, duty_q} - STEP13;
    ramp_res = duty_q;
    if (duty_q < ramp_tgt) begin
      ramp_res = (up_sum >= {1'b0, ramp_tgt}) ? ramp_tgt : up_sum[11:0];
    end else if (duty_q > ramp_tgt) begin
      ramp_res = (dn_diff[12] || (dn_diff <= {1'b0, ramp_tgt})) ? ramp_tgt : dn_diff[11:0];
    end
  end

  // State, duty, direction and dead-counter registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      duty_q  <= 12'd0;
      dir_q   <= 1'b0;
      dead_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
    end
  end

  // Next-state logic: everything moves on period_end except recovery from the illegal encoding.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    case (state_q)
      ST_IDLE: begin
        duty_d = 12'd0;
        if (period_end && cmd_en) begin
          state_d = ST_RUN;
          dir_d   = cmd_dir;
        end
      end
      ST_RUN: begin
        if (period_end) begin
          if (!keep_run && (duty_q == 12'd0)) begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LD;
          end else begin
            duty_d = ramp_res;
          end
        end
      end
      ST_DEAD: begin
        if (period_end) begin
          if (dead_q <= 4'd1) begin
            dead_d = 4'd0;
            duty_d = 12'd0;
            if (cmd_en) begin
              state_d = ST_RUN;
              dir_d   = cmd_dir;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dead_d = dead_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = 12'd0;
        dead_d  = 4'd0;
      end
    endcase
  end

  assign active = (cnt_q < duty_q);

  // Registered leg drives; both derive from one dir_q so they can never be high together.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      pwm_a_q <= active && (state_q == ST_RUN) && !dir_q;
      pwm_b_q <= active && (state_q == ST_RUN) &&  dir_q;
    end
  end

  assign bus.pwm_a     = pwm_a_q;
  assign bus.pwm_b     = pwm_b_q;
  assign bus.at_target = (state_q == ST_RUN) && samp_en_q && (duty_q == samp_tgt_q);
  assign bus.state_o   = state_q;

endmodule
